// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the write-back register file: status codes,
// instruction codes, the "no register" ID and the write-back run/halt states.
package y86_pkg;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } wb_state_e;

    localparam logic [3:0] ICODE_HALT   = 4'd0;
    localparam logic [3:0] ICODE_NOP    = 4'd1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'd2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'd3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'd4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'd5;
    localparam logic [3:0] ICODE_OPQ    = 4'd6;
    localparam logic [3:0] ICODE_JXX    = 4'd7;
    localparam logic [3:0] ICODE_CALL   = 4'd8;
    localparam logic [3:0] ICODE_RET    = 4'd9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'd10;
    localparam logic [3:0] ICODE_POPQ   = 4'd11;

    localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/wb_read_port.sv
// One decode read port: range-checked register select, returning zero for
// RNONE/out-of-range IDs; WB_BYPASS_EN adds a same-cycle write-back forward.
module wb_read_port
    import y86_pkg::*;
#(
    parameter int         DATA_W = 64,
    parameter int         NREGS  = 15,
    parameter logic [3:0] RNONE  = y86_pkg::RNONE
) (
    output logic [DATA_W-1:0] rdata_o,
    input  logic [3:0]        src_i,
`ifdef WB_BYPASS_EN
    input  logic              weE_i,
    input  logic [3:0]        dstE_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic              weM_i,
    input  logic [3:0]        dstM_i,
    input  logic [DATA_W-1:0] valM_i,
`endif
    input  logic [DATA_W-1:0] regs_i [NREGS]
);

    logic srcValid;

    assign srcValid = (src_i != RNONE) && (int'(src_i) < NREGS);

    // Forwarding checks M before E so a pop into %rsp reads the popped value.
    always_comb begin
        rdata_o = '0;
        if (srcValid) begin
            rdata_o = regs_i[src_i];
`ifdef WB_BYPASS_EN
            if (weM_i && (dstM_i == src_i)) begin
                rdata_o = valM_i;
            end else if (weE_i && (dstE_i == src_i)) begin
                rdata_o = valE_i;
            end
`endif
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 write-back register file with halt latching and retire counter.
// Define WB_BYPASS_EN to forward same-cycle writes onto the decode read ports.
module wb_regfile
    import y86_pkg::*;
#(
    parameter int         DATA_W = 64,
    parameter int         NREGS  = 15,
    parameter logic [3:0] RNONE  = y86_pkg::RNONE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        W_stat,
    input  logic [3:0]        W_icode,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    output logic [DATA_W-1:0] d_rvalA,
    output logic [DATA_W-1:0] d_rvalB,
    output logic              halted,
    output logic [1:0]        final_stat,
    output logic [31:0]       retired
);

    wb_state_e         state_q, state_d;
    stat_e             finalStat_q, finalStat_d;
    logic [31:0]       retired_q, retired_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              runEn, aokEn, weE, weM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == ST_RUN) && (W_stat != STAT_AOK)) begin
            state_d = ST_HALTED;
        end
    end

    always_comb begin
        runEn  = (state_q == ST_RUN);
        halted = (state_q == ST_HALTED);
    end

    // A non-AOK status blocks writes on the halting edge itself, not just afterwards.
    assign aokEn = runEn && (W_stat == STAT_AOK);
    assign weE   = aokEn && (W_dstE != RNONE) && (int'(W_dstE) < NREGS);
    assign weM   = aokEn && (W_dstM != RNONE) && (int'(W_dstM) < NREGS);

    always_comb begin
        regs_d      = regs_q;
        finalStat_d = finalStat_q;
        retired_d   = retired_q;
        if (weE) begin
            regs_d[W_dstE] = W_valE;
        end
        if (weM) begin
            regs_d[W_dstM] = W_valM;
        end
        if (runEn && (W_stat != STAT_AOK)) begin
            finalStat_d = stat_e'(W_stat);
        end
        if (aokEn && (W_icode != ICODE_NOP)) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            finalStat_q <= STAT_AOK;
            retired_q   <= '0;
        end else begin
            regs_q      <= regs_d;
            finalStat_q <= finalStat_d;
            retired_q   <= retired_d;
        end
    end

    assign final_stat = finalStat_q;
    assign retired    = retired_q;

    wb_read_port #(.DATA_W(DATA_W), .NREGS(NREGS), .RNONE(RNONE)) uReadA (
        .rdata_o (d_rvalA),
        .src_i   (d_srcA),
`ifdef WB_BYPASS_EN
        .weE_i   (weE),
        .dstE_i  (W_dstE),
        .valE_i  (W_valE),
        .weM_i   (weM),
        .dstM_i  (W_dstM),
        .valM_i  (W_valM),
`endif
        .regs_i  (regs_q)
    );

    wb_read_port #(.DATA_W(DATA_W), .NREGS(NREGS), .RNONE(RNONE)) uReadB (
        .rdata_o (d_rvalB),
        .src_i   (d_srcB),
`ifdef WB_BYPASS_EN
        .weE_i   (weE),
        .dstE_i  (W_dstE),
        .valE_i  (W_valE),
        .weM_i   (weM),
        .dstM_i  (W_dstM),
        .valM_i  (W_valM),
`endif
        .regs_i  (regs_q)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: writes, port-M priority, bypass, bubbles,
// halt freeze and asynchronous reset, with hand-computed expectations.
module tb_wb_regfile;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        W_stat;
    logic [3:0]        W_icode;
    logic [DATA_W-1:0] W_valE, W_valM;
    logic [3:0]        W_dstE, W_dstM;
    logic [3:0]        d_srcA, d_srcB;
    logic [DATA_W-1:0] d_rvalA, d_rvalB;
    logic              halted;
    logic [1:0]        final_stat;
    logic [31:0]       retired;

    int checks = 0;
    int passes = 0;

    wb_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .W_stat     (W_stat),
        .W_icode    (W_icode),
        .W_valE     (W_valE),
        .W_valM     (W_valM),
        .W_dstE     (W_dstE),
        .W_dstM     (W_dstM),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .d_rvalA    (d_rvalA),
        .d_rvalB    (d_rvalB),
        .halted     (halted),
        .final_stat (final_stat),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] stat, input logic [3:0] icode,
                         input logic [3:0] dstE, input logic [63:0] valE,
                         input logic [3:0] dstM, input logic [63:0] valM);
        W_stat  = stat;
        W_icode = icode;
        W_dstE  = dstE;
        W_valE  = valE;
        W_dstM  = dstM;
        W_valM  = valM;
    endtask

    task automatic idle();
        drive(2'd0, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        d_srcA = 4'd1;
        d_srcB = 4'd4;
        #3;
        checks++; if (d_rvalA !== 64'd0) $display("[TB] FAIL reset_rvalA got %0d want 0", d_rvalA); else passes++;
        checks++; if (halted !== 1'b0) $display("[TB] FAIL reset_halted got %0b want 0", halted); else passes++;
        checks++; if (final_stat !== 2'd0) $display("[TB] FAIL reset_final got %0d want 0", final_stat); else passes++;
        checks++; if (retired !== 32'd0) $display("[TB] FAIL reset_retired got %0d want 0", retired); else passes++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_e();
        drive(2'd0, 4'd2, 4'd1, 64'd20, 4'hF, 64'd0);
        step();
        idle();
        d_srcA = 4'd1;
        #1;
        checks++; if (d_rvalA !== 64'd20) $display("[TB] FAIL write_e_reg1 got %0d want 20", d_rvalA); else passes++;
        checks++; if (retired !== 32'd1) $display("[TB] FAIL write_e_retired got %0d want 1", retired); else passes++;
    endtask

    task automatic test_port_m_priority();
        drive(2'd0, 4'd11, 4'd4, 64'd60, 4'd4, 64'd50);
        step();
        drive(2'd0, 4'd5, 4'd6, 64'd7, 4'd7, 64'd8);
        d_srcA = 4'd4;
        #1;
        checks++; if (d_rvalA !== 64'd50) $display("[TB] FAIL popq_reg4 got %0d want 50", d_rvalA); else passes++;
        checks++; if (retired !== 32'd2) $display("[TB] FAIL popq_retired got %0d want 2", retired); else passes++;
        step();
        idle();
        d_srcA = 4'd6;
        d_srcB = 4'd7;
        #1;
        checks++; if (d_rvalA !== 64'd7) $display("[TB] FAIL dual_reg6 got %0d want 7", d_rvalA); else passes++;
        checks++; if (d_rvalB !== 64'd8) $display("[TB] FAIL dual_reg7 got %0d want 8", d_rvalB); else passes++;
        checks++; if (retired !== 32'd3) $display("[TB] FAIL dual_retired got %0d want 3", retired); else passes++;
    endtask

    task automatic test_bypass();
        logic [63:0] expA, expB;
        drive(2'd0, 4'd2, 4'd2, 64'd25, 4'hF, 64'd0);
        d_srcA = 4'd2;
        #1;
`ifdef WB_BYPASS_EN
        expA = 64'd25;
`else
        expA = 64'd0;
`endif
        checks++; if (d_rvalA !== expA) $display("[TB] FAIL bypass_e got %0d want %0d", d_rvalA, expA); else passes++;
        step();
        drive(2'd0, 4'd11, 4'd2, 64'd30, 4'd2, 64'd31);
        d_srcB = 4'd2;
        #1;
`ifdef WB_BYPASS_EN
        expB = 64'd31;
`else
        expB = 64'd25;
`endif
        checks++; if (d_rvalB !== expB) $display("[TB] FAIL bypass_m_over_e got %0d want %0d", d_rvalB, expB); else passes++;
        step();
        idle();
        #1;
        checks++; if (d_rvalA !== 64'd31) $display("[TB] FAIL bypass_reg2 got %0d want 31", d_rvalA); else passes++;
        checks++; if (retired !== 32'd5) $display("[TB] FAIL bypass_retired got %0d want 5", retired); else passes++;
    endtask

    task automatic test_bubble_invalid();
        idle();
        step();
        checks++; if (retired !== 32'd5) $display("[TB] FAIL bubble_retired got %0d want 5", retired); else passes++;
        drive(2'd0, 4'd2, 4'hF, 64'd77, 4'hF, 64'd88);
        step();
        idle();
        d_srcA = 4'd3;
        d_srcB = 4'hF;
        #1;
        checks++; if (retired !== 32'd6) $display("[TB] FAIL rnone_retired got %0d want 6", retired); else passes++;
        checks++; if (d_rvalA !== 64'd0) $display("[TB] FAIL rnone_reg3 got %0d want 0", d_rvalA); else passes++;
        checks++; if (d_rvalB !== 64'd0) $display("[TB] FAIL srcb_rnone got %0d want 0", d_rvalB); else passes++;
    endtask

    task automatic test_halt();
        drive(2'd1, 4'd0, 4'd3, 64'd99, 4'hF, 64'd0);
        d_srcA = 4'd3;
        #1;
        checks++; if (halted !== 1'b0) $display("[TB] FAIL halt_before_edge got %0b want 0", halted); else passes++;
        step();
        drive(2'd0, 4'd2, 4'd3, 64'd11, 4'hF, 64'd0);
        #1;
        checks++; if (halted !== 1'b1) $display("[TB] FAIL halt_halted got %0b want 1", halted); else passes++;
        checks++; if (final_stat !== 2'd1) $display("[TB] FAIL halt_final got %0d want 1", final_stat); else passes++;
        checks++; if (d_rvalA !== 64'd0) $display("[TB] FAIL halt_reg3 got %0d want 0", d_rvalA); else passes++;
        checks++; if (retired !== 32'd6) $display("[TB] FAIL halt_retired got %0d want 6", retired); else passes++;
        step();
        drive(2'd2, 4'd2, 4'd3, 64'd12, 4'hF, 64'd0);
        #1;
        checks++; if (d_rvalA !== 64'd0) $display("[TB] FAIL halted_write_ignored got %0d want 0", d_rvalA); else passes++;
        checks++; if (retired !== 32'd6) $display("[TB] FAIL halted_retired_frozen got %0d want 6", retired); else passes++;
        step();
        #1;
        checks++; if (final_stat !== 2'd1) $display("[TB] FAIL halted_final_frozen got %0d want 1", final_stat); else passes++;
    endtask

    task automatic test_async_reset();
        d_srcA = 4'd1;
        d_srcB = 4'd4;
        rst_n  = 1'b0;
        #2;
        checks++; if (halted !== 1'b0) $display("[TB] FAIL areset_halted got %0b want 0", halted); else passes++;
        checks++; if (final_stat !== 2'd0) $display("[TB] FAIL areset_final got %0d want 0", final_stat); else passes++;
        checks++; if (retired !== 32'd0) $display("[TB] FAIL areset_retired got %0d want 0", retired); else passes++;
        checks++; if (d_rvalA !== 64'd0) $display("[TB] FAIL areset_reg1 got %0d want 0", d_rvalA); else passes++;
        checks++; if (d_rvalB !== 64'd0) $display("[TB] FAIL areset_reg4 got %0d want 0", d_rvalB); else passes++;
        rst_n = 1'b1;
        drive(2'd0, 4'd3, 4'd5, 64'd45, 4'hF, 64'd0);
        step();
        idle();
        d_srcA = 4'd5;
        #1;
        checks++; if (d_rvalA !== 64'd45) $display("[TB] FAIL areset_reg5 got %0d want 45", d_rvalA); else passes++;
        checks++; if (retired !== 32'd1) $display("[TB] FAIL areset_retired_after got %0d want 1", retired); else passes++;
        checks++; if (halted !== 1'b0) $display("[TB] FAIL areset_run got %0b want 0", halted); else passes++;
    endtask

    initial begin
        d_srcA = 4'hF;
        d_srcB = 4'hF;
        test_reset();
        test_write_e();
        test_port_m_priority();
        test_bypass();
        test_bubble_invalid();
        test_halt();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
